lapdfd: RTL and testbench

- Four-lane decision-feedback symbol detector for the 1000BASE-T receive path.
- Sits after the feed-forward equalizer (FFE) and accepts one 8-bit equalized sample per twisted pair per clock.
- Each lane subtracts post-cursor ISI, computed from its own 14 past decisions and a shared 14-tap vector, then slices the result to a PAM5 symbol.
- The four 3-bit symbols are packed into one 12-bit word with a valid flag.

---
 rtl/lapdfd_pkg.sv | 29 ++
 rtl/lapdfd_dfp.sv | 57 +++++
 rtl/lapdfd.sv | 95 +++++++++
 tb/tb_lapdfd.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lapdfd_pkg.sv
// Shared widths, slicer thresholds and PAM5 helpers
// for the four-lane decision-feedback detector.
package lapdfd_pkg;

  localparam int NUM_LANES = 4;
  localparam int NUM_TAPS  = 14;
  localparam int SAMPLE_W  = 8;
  localparam int TAP_W     = 8;
  localparam int FILT_W    = 14;
  localparam int SYM_W     = 3;

  localparam int TH_LO = 26;
  localparam int TH_HI = 77;

  typedef logic signed [SYM_W-1:0] pam5_sym_t;

  function automatic pam5_sym_t slice_pam5(
    input logic signed [FILT_W-1:0] f
  );
    pam5_sym_t s;
    if (f <= -TH_HI)      s = -3'sd2;
    else if (f <= -TH_LO) s = -3'sd1;
    else if (f < TH_LO)   s = 3'sd0;
    else if (f < TH_HI)   s = 3'sd1;
    else                  s = 3'sd2;
    return s;
  endfunction

endpackage

// File: rtl/lapdfd_dfp.sv
// One detector lane: 14-deep decision history, feedback MAC,
// PAM5 slicer and the registered decision.
module lapdfd_dfp
  import lapdfd_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [SAMPLE_W-1:0] io_sample,
  input  logic signed [TAP_W-1:0]  io_taps [NUM_TAPS],
  output logic signed [FILT_W-1:0] io_rxFilter,
  output pam5_sym_t                io_symbol
);

  pam5_sym_t hist_q [NUM_TAPS];
  pam5_sym_t sym_d;
  pam5_sym_t sym_q;

  logic signed [FILT_W-1:0] acc;
  logic signed [FILT_W-1:0] tx;
  logic signed [FILT_W-1:0] hx;

  // Worst-case magnitude fits FILT_W, so modular 14-bit math is exact.
  always_comb begin
    acc = {{(FILT_W-SAMPLE_W){io_sample[SAMPLE_W-1]}}, io_sample};
    tx  = '0;
    hx  = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      tx  = {{(FILT_W-TAP_W){io_taps[k][TAP_W-1]}}, io_taps[k]};
      hx  = {{(FILT_W-SYM_W){hist_q[k][SYM_W-1]}}, hist_q[k]};
      acc = acc - tx * hx;
    end
  end

  assign io_rxFilter = acc;

  always_comb begin
    sym_d = slice_pam5(acc);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sym_q <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      sym_q     <= sym_d;
      hist_q[0] <= sym_d;
      for (int k = 1; k < NUM_TAPS; k++) begin
        hist_q[k] <= hist_q[k-1];
      end
    end
  end

  assign io_symbol = sym_q;

endmodule

// File: rtl/lapdfd.sv
// Four-lane DFE symbol detector: shared taps, per-lane
// feedback, packed symbol word and output valid.
module lapdfd
  import lapdfd_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_rxSamples_0,
  input  logic [7:0]  io_rxSamples_1,
  input  logic [7:0]  io_rxSamples_2,
  input  logic [7:0]  io_rxSamples_3,
  input  logic [7:0]  io_taps_0,
  input  logic [7:0]  io_taps_1,
  input  logic [7:0]  io_taps_2,
  input  logic [7:0]  io_taps_3,
  input  logic [7:0]  io_taps_4,
  input  logic [7:0]  io_taps_5,
  input  logic [7:0]  io_taps_6,
  input  logic [7:0]  io_taps_7,
  input  logic [7:0]  io_taps_8,
  input  logic [7:0]  io_taps_9,
  input  logic [7:0]  io_taps_10,
  input  logic [7:0]  io_taps_11,
  input  logic [7:0]  io_taps_12,
  input  logic [7:0]  io_taps_13,
  output logic [11:0] io_rxSymbols,
  output logic        io_rxValid
);

  logic signed [TAP_W-1:0] taps [NUM_TAPS];
  pam5_sym_t sym [NUM_LANES];
  logic valid_q;

  always_comb begin
    taps[0]  = io_taps_0;
    taps[1]  = io_taps_1;
    taps[2]  = io_taps_2;
    taps[3]  = io_taps_3;
    taps[4]  = io_taps_4;
    taps[5]  = io_taps_5;
    taps[6]  = io_taps_6;
    taps[7]  = io_taps_7;
    taps[8]  = io_taps_8;
    taps[9]  = io_taps_9;
    taps[10] = io_taps_10;
    taps[11] = io_taps_11;
    taps[12] = io_taps_12;
    taps[13] = io_taps_13;
  end

  lapdfd_dfp dfp_0 (
    .clock       (clock),
    .reset       (reset),
    .io_sample   (io_rxSamples_0),
    .io_taps     (taps),
    .io_rxFilter (),
    .io_symbol   (sym[0])
  );

  lapdfd_dfp dfp_1 (
    .clock       (clock),
    .reset       (reset),
    .io_sample   (io_rxSamples_1),
    .io_taps     (taps),
    .io_rxFilter (),
    .io_symbol   (sym[1])
  );

  lapdfd_dfp dfp_2 (
    .clock       (clock),
    .reset       (reset),
    .io_sample   (io_rxSamples_2),
    .io_taps     (taps),
    .io_rxFilter (),
    .io_symbol   (sym[2])
  );

  lapdfd_dfp dfp_3 (
    .clock       (clock),
    .reset       (reset),
    .io_sample   (io_rxSamples_3),
    .io_taps     (taps),
    .io_rxFilter (),
    .io_symbol   (sym[3])
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= 1'b1;
  end

  assign io_rxSymbols = {sym[0], sym[1], sym[2], sym[3]};
  assign io_rxValid   = valid_q;

endmodule

// File: tb/tb_lapdfd.sv
// Directed self-checking bench for lapdfd: vector table
// for the slicer plus feedback, extreme and reset sequences.
module tb_lapdfd;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  smp  [4];
  logic [7:0]  taps [14];
  logic [11:0] io_rxSymbols;
  logic        io_rxValid;

  int checks = 0;
  int failures = 0;

  lapdfd dut (
    .clock          (clock),
    .reset          (reset),
    .io_rxSamples_0 (smp[0]),
    .io_rxSamples_1 (smp[1]),
    .io_rxSamples_2 (smp[2]),
    .io_rxSamples_3 (smp[3]),
    .io_taps_0      (taps[0]),
    .io_taps_1      (taps[1]),
    .io_taps_2      (taps[2]),
    .io_taps_3      (taps[3]),
    .io_taps_4      (taps[4]),
    .io_taps_5      (taps[5]),
    .io_taps_6      (taps[6]),
    .io_taps_7      (taps[7]),
    .io_taps_8      (taps[8]),
    .io_taps_9      (taps[9]),
    .io_taps_10     (taps[10]),
    .io_taps_11     (taps[11]),
    .io_taps_12     (taps[12]),
    .io_taps_13     (taps[13]),
    .io_rxSymbols   (io_rxSymbols),
    .io_rxValid     (io_rxValid)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          s [4];
    logic [11:0] sym;
  } vec_t;

  vec_t vecs [4];

  function automatic int filt(input int l);
    int r;
    case (l)
      0:       r = int'(dut.dfp_0.io_rxFilter);
      1:       r = int'(dut.dfp_1.io_rxFilter);
      2:       r = int'(dut.dfp_2.io_rxFilter);
      default: r = int'(dut.dfp_3.io_rxFilter);
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_taps(input int v);
    for (int k = 0; k < 14; k++) taps[k] = 8'(v);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{s: '{-103, -52, 51, 101}, sym: 12'hDCA};
    vecs[1] = '{s: '{25, 26, -26, -77},   sym: 12'h07E};
    vecs[2] = '{s: '{76, 77, 0, -128},    sym: 12'h286};
    vecs[3] = '{s: '{127, -78, -25, -27}, sym: 12'h587};

    reset = 1'b1;
    set_taps(0);
    for (int l = 0; l < 4; l++) smp[l] = '0;

    // reset behaviour
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", int'(io_rxValid), 0);
    chk("rst_sym", int'(io_rxSymbols), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rel_valid_pre_edge", int'(io_rxValid), 0);
    @(posedge clock);
    #1;
    chk("valid_after_edge", int'(io_rxValid), 1);
    chk("sym_zero_input", int'(io_rxSymbols), 0);

    // zero-tap slicer table
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      for (int l = 0; l < 4; l++) smp[l] = 8'(vecs[i].s[l]);
      #1;
      for (int l = 0; l < 4; l++)
        chk($sformatf("tbl%0d_filt%0d", i, l), filt(l), vecs[i].s[l]);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_sym", i), int'(io_rxSymbols), int'(vecs[i].sym));
      chk($sformatf("tbl%0d_valid", i), int'(io_rxValid), 1);
    end

    // taps[0]=20 feedback of previous decision
    pulse_reset();
    for (int l = 0; l < 4; l++) smp[l] = '0;
    taps[0] = 8'd20;
    smp[0] = 8'd51;
    #1;
    chk("t0_first_filt", filt(0), 51);
    @(posedge clock);
    #1;
    chk("t0_first_sym", int'(io_rxSymbols[11:9]), 1);
    @(negedge clock);
    smp[0] = 8'd71;
    #1;
    chk("t0_second_filt", filt(0), 51);
    @(posedge clock);
    #1;
    chk("t0_second_sym", int'(io_rxSymbols[11:9]), 1);

    // taps[13]=10 sees a decision 14 cycles back
    set_taps(0);
    pulse_reset();
    taps[13] = 8'd10;
    smp[0] = 8'd101;
    @(posedge clock);
    #1;
    chk("t13_seed_sym", int'(io_rxSymbols[11:9]), 2);
    @(negedge clock);
    smp[0] = 8'd0;
    for (int c = 0; c < 13; c++) begin
      @(posedge clock);
      #1;
    end
    chk("t13_gap_sym", int'(io_rxSymbols[11:9]), 0);
    @(negedge clock);
    smp[0] = 8'd60;
    #1;
    chk("t13_filt", filt(0), 40);
    @(posedge clock);
    #1;
    chk("t13_sym", int'(io_rxSymbols[11:9]), 1);

    // extreme: history all +2, taps all 127, sample -128
    set_taps(0);
    @(negedge clock);
    smp[0] = 8'd101;
    repeat (14) @(posedge clock);
    @(negedge clock);
    set_taps(127);
    smp[0] = 8'h80;
    #1;
    chk("ext_filt", filt(0), -3684);
    chk("ext_filt_lane1", filt(1), 0);
    @(posedge clock);
    #1;
    chk("ext_sym", int'(io_rxSymbols), 12'hC00);

    // asynchronous reset mid-stream
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_sym", int'(io_rxSymbols), 0);
    chk("mid_rst_valid", int'(io_rxValid), 0);
    @(negedge clock);
    reset = 1'b0;
    smp[0] = 8'd50;
    #1;
    chk("post_rst_filt", filt(0), 50);
    @(posedge clock);
    #1;
    chk("post_rst_sym", int'(io_rxSymbols[11:9]), 1);
    chk("post_rst_valid", int'(io_rxValid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
